program_loader: RTL and testbench

- Hardware boot loader between an instruction source (debug port, UART bridge or bench) and the `computer` program memory write port.
- On each load session it:
  - holds the core in reset;
  - fills the whole program memory with a fill instruction (HALT encoding);
  - streams in `length` instructions over a valid/ready handshake, written to addresses 0 upward;
  - holds reset for a programmable settle time, then releases the core.
- Parametrised in instruction width, memory depth and release delay.

---
 rtl/program_loader.sv | 114 +++++++++++
 tb/tb_program_loader.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Boot loader: holds the core in reset, fills program memory with FILL_INST,
// streams in `length` instructions from address 0, then releases the core.
module program_loader #(
  parameter int unsigned INST_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter logic [INST_WIDTH-1:0] FILL_INST = 16'hFFFF,
  parameter int unsigned RELEASE_CYCLES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INST_WIDTH-1:0] in_inst,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [INST_WIDTH-1:0] mem_wdata,
  output logic                  core_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] FILL_LAST = (ADDR_WIDTH + 1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH + 1)'(1);
  localparam int unsigned REL_W = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
  localparam logic [REL_W-1:0] REL_LAST = REL_W'(RELEASE_CYCLES - 1);
  localparam logic [REL_W-1:0] REL_ONE = REL_W'(1);

  typedef enum logic [2:0] {StIdle, StFill, StLoad, StRelease, StRun} state_e;

  state_e              state;
  logic [ADDR_WIDTH:0] cnt;  // fill address in FILL, transfer count in LOAD
  logic [ADDR_WIDTH:0] len;
  logic [REL_W-1:0]    rel_cnt;

  assign in_ready = (state == StLoad) && (cnt < len);
  assign busy     = (state == StFill) || (state == StLoad) || (state == StRelease);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= StIdle;
      cnt        <= '0;
      len        <= '0;
      rel_cnt    <= '0;
      core_reset <= 1'b1;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
      unique case (state)
        StIdle, StRun: begin
          if (start) begin
            if (length > DEPTH_W) begin
              error <= 1'b1;
            end else begin
              // First fill write goes out on this edge; FILL covers the rest.
              error      <= 1'b0;
              len        <= length;
              core_reset <= 1'b1;
              state      <= StFill;
              mem_we     <= 1'b1;
              mem_addr   <= '0;
              mem_wdata  <= FILL_INST;
              cnt        <= CNT_ONE;
            end
          end
        end
        StFill: begin
          mem_we    <= 1'b1;
          mem_addr  <= cnt[ADDR_WIDTH-1:0];
          mem_wdata <= FILL_INST;
          if (cnt == FILL_LAST) begin
            cnt     <= '0;
            rel_cnt <= '0;
            state   <= (len == '0) ? StRelease : StLoad;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        StLoad: begin
          if (in_valid && in_ready) begin
            mem_we    <= 1'b1;
            mem_addr  <= cnt[ADDR_WIDTH-1:0];
            mem_wdata <= in_inst;
            cnt       <= cnt + CNT_ONE;
            if (cnt + CNT_ONE == len) begin
              rel_cnt <= '0;
              state   <= StRelease;
            end
          end
        end
        StRelease: begin
          if (rel_cnt == REL_LAST) begin
            core_reset <= 1'b0;
            done       <= 1'b1;
            state      <= StRun;
          end else begin
            rel_cnt <= rel_cnt + REL_ONE;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader: a per-cycle model of the load session
// timeline plus a model of program memory contents.
module tb_program_loader;

  localparam int D = 16;
  localparam int R = 2;
  localparam int LIMIT = 300;
  localparam logic [15:0] FILL = 16'hFFFF;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  length;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_inst;
  logic        mem_we;
  logic [3:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        core_reset;
  logic        busy;
  logic        done;
  logic        error;

  int applied = 0;
  int miscompares = 0;

  logic [15:0] shadow  [D];
  logic [15:0] exp_mem [D];

  program_loader #(
    .INST_WIDTH(16),
    .ADDR_WIDTH(4),
    .FILL_INST(16'hFFFF),
    .RELEASE_CYCLES(R)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .length(length),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_inst(in_inst),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .core_reset(core_reset),
    .busy(busy),
    .done(done),
    .error(error)
  );

  always #5 clock = ~clock;

  // mode: 0 = valid always high, 1 = valid every other cycle, 2 = random valid.
  // poke: pulse a random start in the middle of FILL, which must be ignored.
  task automatic run_session(input int len, input int mode, input bit poke,
                             output int done_at, output int idle);
    int k, n, done_edge;
    bit pend, ew, ready_m, v;
    logic [3:0] pend_addr, ea;
    logic [15:0] pend_data, ed, inst;
    for (int i = 0; i < D; i++) exp_mem[i] = FILL;
    @(negedge clock);
    start = 1'b1; length = len[4:0]; in_valid = 1'b1; in_inst = 16'hDEAD;
    @(negedge clock);
    start = 1'b0; in_valid = 1'b0;
    n = 0; pend = 1'b0; done_at = -1; idle = 0; k = 0;
    pend_addr = '0; pend_data = '0;
    done_edge = (len == 0) ? D - 1 + R : (1 << 30);
    while (k <= done_edge + 1 && k < LIMIT) begin
      if (k < D) begin
        ew = 1'b1; ea = k[3:0]; ed = FILL;
      end else begin
        ew = pend; ea = pend_addr; ed = pend_data;
      end
      pend = 1'b0;
      applied++;
      if (mem_we !== ew || (ew && (mem_addr !== ea || mem_wdata !== ed))) begin
        miscompares++;
        $display("FAIL write k=%0d: got we=%b addr=%0d data=%h, expected we=%b addr=%0d data=%h",
                 k, mem_we, mem_addr, mem_wdata, ew, ea, ed);
      end
      if (mem_we === 1'b1) shadow[mem_addr] = mem_wdata;
      applied++;
      if (core_reset !== (k < done_edge) || busy !== (k < done_edge)) begin
        miscompares++;
        $display("FAIL core_reset/busy k=%0d: got %b/%b, expected %b", k, core_reset, busy,
                 (k < done_edge));
      end
      applied++;
      if (done !== (k == done_edge) || error !== 1'b0) begin
        miscompares++;
        $display("FAIL done/error k=%0d: got %b/%b, expected %b/0", k, done, error,
                 (k == done_edge));
      end
      if (done === 1'b1 && done_at < 0) done_at = k;
      ready_m = (k + 1 >= D) && (n < len);
      applied++;
      if (in_ready !== ready_m) begin
        miscompares++;
        $display("FAIL in_ready k=%0d: got %b, expected %b", k, in_ready, ready_m);
      end
      case (mode)
        0: v = 1'b1;
        1: v = (k % 2 == 1);
        default: v = 1'($urandom_range(0, 1));
      endcase
      inst = 16'($urandom);
      in_valid = v; in_inst = inst;
      if (poke && k == 3) begin
        start = 1'b1; length = 5'($urandom_range(0, 17));
      end else begin
        start = 1'b0;
      end
      if (ready_m && !v) idle++;
      if (v && ready_m) begin
        pend = 1'b1; pend_addr = n[3:0]; pend_data = inst;
        exp_mem[n] = inst;
        n++;
        if (n == len) done_edge = k + 1 + R;
      end
      @(negedge clock);
      k++;
    end
    in_valid = 1'b0; start = 1'b0;
    applied++;
    if (n != len || done_at < 0) begin
      miscompares++;
      $display("FAIL session_complete: got %0d transfers done_at=%0d, expected %0d and a done",
               n, done_at, len);
    end
    for (int i = 0; i < D; i++) begin
      applied++;
      if (shadow[i] !== exp_mem[i]) begin
        miscompares++;
        $display("FAIL memory[%0d]: got %h, expected %h", i, shadow[i], exp_mem[i]);
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; length = '0; in_valid = 1'b0; in_inst = '0;
    repeat (2) @(negedge clock);
    applied++;
    if (core_reset !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 4'd0 || mem_wdata !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_mem: got cr=%b we=%b addr=%0d data=%h, expected 1 0 0 0000",
               core_reset, mem_we, mem_addr, mem_wdata);
    end
    reset = 1'b0;
    @(negedge clock);
    applied++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || error !== 1'b0
        || core_reset !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_idle: got rdy=%b busy=%b done=%b err=%b cr=%b, expected 0 0 0 0 1",
               in_ready, busy, done, error, core_reset);
    end
  endtask

  task automatic test_basic;
    int d, idle;
    run_session(8, 0, 1'b0, d, idle);
    applied++;
    if (d !== D + 8 - 1 + R) begin
      miscompares++;
      $display("FAIL basic_latency: got done after edge %0d, expected %0d", d, D + 8 - 1 + R);
    end
  endtask

  task automatic test_backpressure;
    int d, idle;
    run_session(8, 1, 1'b0, d, idle);
    applied++;
    if (idle == 0 || d !== D + 8 - 1 + R + idle) begin
      miscompares++;
      $display("FAIL backpressure_latency: got %0d (idle %0d), expected %0d", d, idle,
               D + 8 - 1 + R + idle);
    end
  endtask

  task automatic test_zero_length;
    int d, idle;
    run_session(0, 0, 1'b0, d, idle);
    applied++;
    if (d !== D - 1 + R || core_reset !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_length: got done at %0d cr=%b, expected %0d cr=0", d, core_reset,
               D - 1 + R);
    end
  endtask

  task automatic test_overflow;
    int d, idle;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    start = 1'b1; length = 5'd17; in_valid = 1'b1;
    @(negedge clock);
    start = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applied++;
      if (error !== 1'b1 || mem_we !== 1'b0 || core_reset !== 1'b1 || busy !== 1'b0
          || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL overflow_idle: got err=%b we=%b cr=%b busy=%b rdy=%b, expected 1 0 1 0 0",
                 error, mem_we, core_reset, busy, in_ready);
      end
      @(negedge clock);
    end
    run_session(16, 2, 1'b0, d, idle);
  endtask

  task automatic test_restart;
    int d, idle;
    @(negedge clock);
    start = 1'b1; length = 5'd17;
    @(negedge clock);
    start = 1'b0;
    applied++;
    if (error !== 1'b1 || core_reset !== 1'b0 || busy !== 1'b0 || mem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL overflow_run: got err=%b cr=%b busy=%b we=%b, expected 1 0 0 0",
               error, core_reset, busy, mem_we);
    end
    run_session(4, 0, 1'b1, d, idle);
  endtask

  task automatic test_back_to_back;
    int d, idle;
    for (int s = 0; s < 4; s++) begin
      run_session(int'($urandom_range(0, 16)), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                  d, idle);
    end
  endtask

  task automatic test_abort;
    int d, idle;
    @(negedge clock);
    start = 1'b1; length = 5'd8; in_valid = 1'b1; in_inst = 16'h1234;
    @(negedge clock);
    start = 1'b0;
    repeat (D + 2) @(negedge clock);
    applied++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_in_load: got rdy=%b busy=%b, expected 1 1", in_ready, busy);
    end
    #2 reset = 1'b1;
    #1;
    applied++;
    if (core_reset !== 1'b1 || mem_we !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_async: got cr=%b we=%b rdy=%b busy=%b, expected 1 0 0 0",
               core_reset, mem_we, in_ready, busy);
    end
    @(negedge clock);
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clock);
    applied++;
    if (core_reset !== 1'b1 || mem_we !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_idle: got cr=%b we=%b rdy=%b busy=%b, expected 1 0 0 0",
               core_reset, mem_we, in_ready, busy);
    end
    run_session(5, 2, 1'b0, d, idle);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_length();
    test_overflow();
    test_restart();
    test_back_to_back();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
